// File: rtl/icache_fetch_responder.sv
// Direct-mapped, read-only instruction cache answering the fetch stage's
// icache_read/icache_resp handshake; misses fill one 128-bit line from pmem.
module icache_fetch_responder #(
  parameter int NUM_SETS = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             icache_read,
  input  logic [15:0]      icache_address,
  output logic             icache_resp,
  output logic [15:0]      icache_rdata,
  output logic             pmem_read,
  output logic [15:0]      pmem_address,
  input  logic             pmem_resp,
  input  logic [127:0]     pmem_rdata,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 12 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state;
  logic [NUM_SETS-1:0]   valid;
  logic [TAG_W-1:0]      tag_mem  [NUM_SETS];
  logic [127:0]          line_mem [NUM_SETS];

  logic [IDX_W-1:0]      req_index;
  logic [TAG_W-1:0]      req_tag;
  logic [2:0]            req_word;
  logic [127:0]          req_line;
  logic                  hit;
  logic                  miss;
  logic [IDX_W-1:0]      fill_index;
  logic [TAG_W-1:0]      fill_tag;
  logic                  unused_addr_bit;

  assign req_index       = icache_address[4 +: IDX_W];
  assign req_tag         = icache_address[15 -: TAG_W];
  assign req_word        = icache_address[3:1];
  assign req_line        = line_mem[req_index];
  assign unused_addr_bit = icache_address[0];

  // The fill target is recovered from the registered line address, which
  // stays constant for the whole FILL state.
  assign fill_index = pmem_address[4 +: IDX_W];
  assign fill_tag   = pmem_address[15 -: TAG_W];

  assign hit  = (state == IDLE) && icache_read && valid[req_index] &&
                (tag_mem[req_index] == req_tag);
  assign miss = (state == IDLE) && icache_read && !hit;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    icache_resp  = 1'b0;
    icache_rdata = '0;
    if (hit) begin
      icache_resp  = 1'b1;
      icache_rdata = req_line[{req_word, 4'h0} +: 16];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      valid        <= '0;
      pmem_read    <= 1'b0;
      pmem_address <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      if (hit && (hit_count != '1))
        hit_count <= hit_count + CNT_W'(1);

      case (state)
        IDLE: begin
          if (miss) begin
            state        <= FILL;
            pmem_read    <= 1'b1;
            pmem_address <= {icache_address[15:4], 4'h0};
            if (miss_count != '1)
              miss_count <= miss_count + CNT_W'(1);
          end
        end
        FILL: begin
          // A redirect during the fill does not abort it; the line installs anyway.
          if (pmem_resp) begin
            state             <= IDLE;
            pmem_read         <= 1'b0;
            valid[fill_index] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag and line storage are deliberately not reset; the valid bits
  // alone decide whether their contents are meaningful.
  always_ff @(posedge clk) begin
    if ((state == FILL) && pmem_resp) begin
      line_mem[fill_index] <= pmem_rdata;
      tag_mem[fill_index]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed bench for icache_fetch_responder: cold miss, hit, conflict eviction,
// redirect mid-fill, reset mid-fill and hit-counter saturation (CNT_W=4).
module tb_icache_fetch_responder;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             icache_read;
  logic [15:0]      icache_address;
  logic             icache_resp;
  logic [15:0]      icache_rdata;
  logic             pmem_read;
  logic [15:0]      pmem_address;
  logic             pmem_resp;
  logic [127:0]     pmem_rdata;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] LINE_A = 128'hBEEF_A006_A005_A004_A003_A002_1234_A000;
  localparam logic [127:0] LINE_B = 128'h0107_0106_0105_0104_0103_0102_0101_5555;
  localparam logic [127:0] LINE_C = 128'h0C07_0C06_0C05_0C04_0C03_7777_0C01_0C00;
  localparam logic [127:0] LINE_D = 128'h0D07_0D06_0D05_0D04_0D03_0D02_0D01_0F0F;

  icache_fetch_responder #(.NUM_SETS(8), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .icache_resp    (icache_resp),
    .icache_rdata   (icache_rdata),
    .pmem_read      (pmem_read),
    .pmem_address   (pmem_address),
    .pmem_resp      (pmem_resp),
    .pmem_rdata     (pmem_rdata),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Miss on addr, pmem answers on the lat-th FILL cycle, then the response cycle.
  // Leaves icache_read asserted at the end of the response cycle.
  task automatic miss_fill(input logic [15:0] addr, input logic [127:0] line,
                           input int lat, input logic [15:0] exp_word);
    next_cycle();
    icache_read    = 1'b1;
    icache_address = addr;
    @(negedge clk);
    check("miss_no_resp", 32'(icache_resp), 32'd0);
    for (int i = 1; i <= lat; i++) begin
      next_cycle();
      pmem_resp  = (i == lat);
      pmem_rdata = line;
      @(negedge clk);
      check("fill_pmem_read", 32'(pmem_read), 32'd1);
      check("fill_pmem_addr", 32'(pmem_address), 32'({addr[15:4], 4'h0}));
      check("fill_no_resp", 32'(icache_resp), 32'd0);
    end
    next_cycle();
    pmem_resp = 1'b0;
    @(negedge clk);
    check("fill_resp", 32'(icache_resp), 32'd1);
    check("fill_rdata", 32'(icache_rdata), 32'(exp_word));
    check("fill_pmem_idle", 32'(pmem_read), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    icache_read    = 1'b0;
    icache_address = '0;
    pmem_resp      = 1'b0;
    pmem_rdata     = '0;

    // Reset values
    @(negedge clk);
    check("rst_resp", 32'(icache_resp), 32'd0);
    check("rst_rdata", 32'(icache_rdata), 32'd0);
    check("rst_pmem_read", 32'(pmem_read), 32'd0);
    check("rst_pmem_addr", 32'(pmem_address), 32'd0);
    check("rst_hits", 32'(hit_count), 32'd0);
    check("rst_misses", 32'(miss_count), 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // 1: cold miss on 0x3002, 5-cycle fill, word1 returned on cycle 6
    miss_fill(16'h3002, LINE_A, 5, 16'h1234);
    check("cold_miss_count", 32'(miss_count), 32'd1);
    check("cold_hit_count", 32'(hit_count), 32'd0);

    // 2: hit on word7 of the same line, same cycle, no fill
    next_cycle();
    icache_address = 16'h300E;
    @(negedge clk);
    check("hit_resp", 32'(icache_resp), 32'd1);
    check("hit_rdata", 32'(icache_rdata), 32'hBEEF);
    check("hit_no_pmem", 32'(pmem_read), 32'd0);
    check("hit_count_1", 32'(hit_count), 32'd1);
    next_cycle();
    icache_read = 1'b0;
    @(negedge clk);
    check("idle_resp", 32'(icache_resp), 32'd0);
    check("idle_rdata", 32'(icache_rdata), 32'd0);
    check("hit_count_2", 32'(hit_count), 32'd2);

    // 3: conflict in set 0 evicts 0x3000, which then misses again
    miss_fill(16'h3080, LINE_B, 3, 16'h5555);
    miss_fill(16'h3000, LINE_A, 2, 16'hA000);
    check("conflict_miss_count", 32'(miss_count), 32'd3);
    check("conflict_hit_count", 32'(hit_count), 32'd3);

    // 4: redirect two cycles into the fill of 0x4000
    next_cycle();
    icache_address = 16'h4000;
    @(negedge clk);
    check("redir_miss", 32'(icache_resp), 32'd0);
    next_cycle();
    @(negedge clk);
    check("redir_fill", 32'(pmem_read), 32'd1);
    next_cycle();
    icache_read = 1'b0;
    @(negedge clk);
    check("redir_still_fill", 32'(pmem_read), 32'd1);
    next_cycle();
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_C;
    @(negedge clk);
    check("redir_no_resp", 32'(icache_resp), 32'd0);
    check("redir_rdata0", 32'(icache_rdata), 32'd0);
    next_cycle();
    pmem_resp = 1'b0;
    @(negedge clk);
    check("redir_done", 32'(pmem_read), 32'd0);
    check("redir_idle_resp", 32'(icache_resp), 32'd0);
    next_cycle();
    icache_read    = 1'b1;
    icache_address = 16'h4004;
    @(negedge clk);
    check("redir_later_hit", 32'(icache_resp), 32'd1);
    check("redir_later_rdata", 32'(icache_rdata), 32'h7777);
    check("redir_miss_count", 32'(miss_count), 32'd4);
    check("redir_hit_count", 32'(hit_count), 32'd4);

    // 5: reset during FILL; the late pmem_resp must be ignored
    next_cycle();
    icache_address = 16'h5000;
    @(negedge clk);
    check("rfill_miss", 32'(icache_resp), 32'd0);
    next_cycle();
    @(negedge clk);
    check("rfill_pmem_read", 32'(pmem_read), 32'd1);
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    check("rfill_rst_pmem_read", 32'(pmem_read), 32'd0);
    check("rfill_rst_pmem_addr", 32'(pmem_address), 32'd0);
    check("rfill_rst_misses", 32'(miss_count), 32'd0);
    check("rfill_rst_hits", 32'(hit_count), 32'd0);
    next_cycle();
    rst_n       = 1'b1;
    icache_read = 1'b0;
    pmem_resp   = 1'b1;
    pmem_rdata  = LINE_D;
    @(negedge clk);
    check("rfill_late_ignored", 32'(pmem_read), 32'd0);
    next_cycle();
    pmem_resp = 1'b0;
    miss_fill(16'h5000, LINE_D, 2, 16'h0F0F);
    check("rfill_miss_count", 32'(miss_count), 32'd1);

    // 6: 20 more consecutive hits saturate the 4-bit hit counter at 15
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      icache_address = (i % 2 == 0) ? 16'h5002 : 16'h5000;
      @(negedge clk);
      if (i == 10) check("sat_mid", 32'(hit_count), 32'd11);
    end
    check("sat_last_resp", 32'(icache_resp), 32'd1);
    next_cycle();
    icache_read = 1'b0;
    @(negedge clk);
    check("sat_hold_15", 32'(hit_count), 32'd15);
    check("sat_miss_count", 32'(miss_count), 32'd1);
    next_cycle();
    @(negedge clk);
    check("sat_still_15", 32'(hit_count), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
